// File: rtl/lstm_state_buffer.sv
// lstm_state_buffer
//   Ping-pong capture of the per-unit LSTM cell state (c) and hidden state (h).
//   The bank selected by wr_bank_q is filled one unit at a time during a timestep.
//   The other bank (~wr_bank_q) serves the previous timestep through a one-cycle
//   random-access read port. zero_init_q forces reads to zero until the first
//   completed timestep of a sequence has been swapped in.
//
//   Optional feature: define STATE_BUF_STEP_CNT_EN to add the saturating
//   step_count output, which counts step_done pulses since seq_start or reset.
//
//   Handshakes: c_valid/h_valid are single-cycle strobes with no backpressure,
//   one per unit, and are dropped when they cannot be accepted.
//   rd_en/rd_valid form a fixed-latency pair: rd_en in cycle n gives rd_valid
//   with data in cycle n+1. There is no stall.
module lstm_state_buffer #(
    parameter int DATA_WIDTH  = 16,
    parameter int HIDDEN_SIZE = 64,
    parameter int ADDR_WIDTH  = 6     // must equal $clog2(HIDDEN_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  seq_start,
    input  logic                  step_start,
    input  logic [DATA_WIDTH-1:0] c_in,
    input  logic                  c_valid,
    input  logic [DATA_WIDTH-1:0] h_in,
    input  logic                  h_valid,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] c_prev,
    output logic [DATA_WIDTH-1:0] h_prev,
    output logic                  rd_valid,
    output logic                  step_done,
    output logic                  busy,
    output logic                  err
`ifdef STATE_BUF_STEP_CNT_EN
    ,
    output logic [15:0]           step_count
`endif
);

    // The pointers must be able to hold HIDDEN_SIZE itself, so they need one extra bit.
    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(HIDDEN_SIZE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    wr_bank_q, wr_bank_d;
    logic                    zero_init_q, zero_init_d;
    logic [PTR_W-1:0]        c_wptr_q, c_wptr_d;
    logic [PTR_W-1:0]        h_wptr_q, h_wptr_d;
    logic                    err_q, err_d;
    logic                    step_done_q, step_done_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]   c_prev_q, c_prev_d;
    logic [DATA_WIDTH-1:0]   h_prev_q, h_prev_d;

    // Bank storage. It is not reset, because zero_init_q masks stale contents.
    logic [DATA_WIDTH-1:0]   c_bank_q [2][HIDDEN_SIZE];
    logic [DATA_WIDTH-1:0]   h_bank_q [2][HIDDEN_SIZE];

    logic c_full, h_full;
    logic start_fill, swap;
    logic c_wr, h_wr;
    logic rd_oob;
    logic proto_err;

    assign c_full = (c_wptr_q == FULL_PTR);
    assign h_full = (h_wptr_q == FULL_PTR);
    assign rd_oob = ({1'b0, rd_addr} >= FULL_PTR);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. seq_start overrides every transition.
    always_comb begin
        state_d = state_q;
        if (seq_start) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (step_start) state_d = S_FILL;
                S_FILL:  if (c_full && h_full) state_d = S_DONE;
                S_DONE:  if (step_start) state_d = S_FILL;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs: the step_done pulse and the busy level
    always_comb begin
        step_done_d = !seq_start && (state_q == S_FILL) && c_full && h_full;
        busy        = (state_q == S_FILL);
    end

    // Capture control: pointers, bank select, zero-init mask and sticky error
    always_comb begin
        start_fill = !seq_start && step_start && (state_q != S_FILL);
        swap       = !seq_start && step_start && (state_q == S_DONE);
        c_wr       = !seq_start && (state_q == S_FILL) && c_valid && !c_full;
        h_wr       = !seq_start && (state_q == S_FILL) && h_valid && !h_full;

        c_wptr_d = c_wptr_q;
        if (seq_start || start_fill) c_wptr_d = '0;
        else if (c_wr)               c_wptr_d = c_wptr_q + 1'b1;

        h_wptr_d = h_wptr_q;
        if (seq_start || start_fill) h_wptr_d = '0;
        else if (h_wr)               h_wptr_d = h_wptr_q + 1'b1;

        wr_bank_d   = wr_bank_q ^ swap;
        zero_init_d = zero_init_q;
        if (seq_start)  zero_init_d = 1'b1;
        else if (swap)  zero_init_d = 1'b0;

        proto_err = ((c_valid || h_valid) && (state_q != S_FILL))
                  || ((state_q == S_FILL) && c_valid && c_full)
                  || ((state_q == S_FILL) && h_valid && h_full)
                  || ((state_q == S_FILL) && step_start)
                  || (rd_en && rd_oob);
        err_d = seq_start ? 1'b0 : (err_q || proto_err);
    end

    // Read port: always from the bank not being written, with zeros while masked
    always_comb begin
        rd_valid_d = rd_en;
        c_prev_d   = c_prev_q;
        h_prev_d   = h_prev_q;
        if (rd_en) begin
            if (zero_init_q || rd_oob) begin
                c_prev_d = '0;
                h_prev_d = '0;
            end else begin
                c_prev_d = c_bank_q[~wr_bank_q][rd_addr];
                h_prev_d = h_bank_q[~wr_bank_q][rd_addr];
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q   <= 1'b0;
            zero_init_q <= 1'b1;
            c_wptr_q    <= '0;
            h_wptr_q    <= '0;
            err_q       <= 1'b0;
            step_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            c_prev_q    <= '0;
            h_prev_q    <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            zero_init_q <= zero_init_d;
            c_wptr_q    <= c_wptr_d;
            h_wptr_q    <= h_wptr_d;
            err_q       <= err_d;
            step_done_q <= step_done_d;
            rd_valid_q  <= rd_valid_d;
            c_prev_q    <= c_prev_d;
            h_prev_q    <= h_prev_d;
        end
    end

    // Bank writes into the fill bank. The data is stored bit-exact.
    always_ff @(posedge clk) begin
        if (c_wr) c_bank_q[wr_bank_q][c_wptr_q[ADDR_WIDTH-1:0]] <= c_in;
        if (h_wr) h_bank_q[wr_bank_q][h_wptr_q[ADDR_WIDTH-1:0]] <= h_in;
    end

    assign c_prev    = c_prev_q;
    assign h_prev    = h_prev_q;
    assign rd_valid  = rd_valid_q;
    assign step_done = step_done_q;
    assign err       = err_q;

`ifdef STATE_BUF_STEP_CNT_EN
    logic [15:0] step_count_q, step_count_d;

    // Saturating count of completed timesteps, which moves with the step_done pulse
    always_comb begin
        step_count_d = step_count_q;
        if (seq_start)                                 step_count_d = '0;
        else if (step_done_d && step_count_q != 16'hFFFF) step_count_d = step_count_q + 16'd1;
    end

    // Step counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_count_q <= '0;
        else        step_count_q <= step_count_d;
    end

    assign step_count = step_count_q;
`endif

endmodule
